// File: rtl/cyq_seq_detect.sv
// Serial sequence detector: matches a gated bit stream against a reloadable
// N-bit pattern, with a registered match pulse and a saturating match counter.
module cyq_seq_detect #(
    parameter int unsigned   N       = 3,
    parameter int unsigned   CNT_W   = 8,
    parameter logic [N-1:0]  PAT_RST = N'(3'b011)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             X,
    input  logic             Load,
    input  logic [N-1:0]     Pattern,
    input  logic             Overlap,
    output logic             Y,
    output logic [CNT_W-1:0] Count,
    output logic             Sat
);

    localparam int unsigned      FW        = $clog2(N + 1);
    localparam logic [FW-1:0]    FILL_FULL = FW'(N);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [N-1:0]     pat_q,  pat_d;
    logic [N-1:0]     hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             y_q,    y_d;

    // NOTE: every next-state signal gets a default first so no latch is inferred.
    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        y_d    = 1'b0;

        if (Load) begin
            pat_d  = Pattern;
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (En) begin
            hist_d = {hist_q[N-2:0], X};
            fill_d = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;

            // Fill gating keeps the reset zeros in hist from ever matching.
            if (fill_d == FILL_FULL && hist_d == pat_q) begin
                y_d = 1'b1;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (!Overlap) begin
                    fill_d = '0;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pat_q  <= PAT_RST;
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            y_q    <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            y_q    <= y_d;
        end
    end

    assign Y     = y_q;
    assign Count = cnt_q;
    assign Sat   = (cnt_q == CNT_MAX);

endmodule
